// File: rtl/key_matrix_scanner.sv
// Column-scanned push-button matrix reader with per-cell debounce; cells bit i*N+j = row group i, column j.
// Optional KEY_SCANNER_EDGE_EN adds a registered rising-edge pulse per cell on `pressed`.
module key_matrix_scanner #(
  parameter int unsigned N              = 3,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_SCANS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         rows_in,
  output logic [N-1:0]         cols_out,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done,
  output logic [N*N-1:0]       pressed
);

  localparam int unsigned XW = $clog2(N) + 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  // Elaboration-time parameter range checks
  if (N < 1 || N > 8) begin : g_bad_n
    $error("key_matrix_scanner: N must be 1..8");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("key_matrix_scanner: SETTLE_CYCLES must be >= 3");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("key_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0]            sync1_q, sync2_q;
  logic [N-1:0]            cols_q, cols_d;
  logic [XW-1:0]           x_q, x_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [N*N-1:0]          cells_q, cells_d;
  logic [N*N-1:0][CW-1:0]  dbc_q, dbc_d;
  logic                    frame_q, frame_d;
  logic                    sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= '1;
      sync2_q  <= '1;
      cols_q   <= '0;
      x_q      <= '0;
      settle_q <= '0;
      cells_q  <= '0;
      dbc_q    <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= rows_in;
      sync2_q  <= sync1_q;
      cols_q   <= cols_d;
      x_q      <= x_d;
      settle_q <= settle_d;
      cells_q  <= cells_d;
      dbc_q    <= dbc_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cols_d   = cols_q;
    x_d      = x_q;
    settle_d = settle_q;
    cells_d  = cells_q;
    dbc_d    = dbc_q;
    frame_d  = 1'b0;
    sample   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d  = SCAN;
          x_d      = '0;
          cols_d   = N'(1);
          settle_d = '0;
        end
      end
      SCAN: begin
        if (!ena) begin
          state_d  = IDLE;
          x_d      = '0;
          cols_d   = '0;
          settle_d = '0;
        end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          sample   = 1'b1;
          settle_d = '0;
          frame_d  = (x_q == XW'(N - 1));
          x_d      = (x_q == XW'(N - 1)) ? '0 : x_q + XW'(1);
          cols_d   = N'(1) << x_d;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Debounce only the cells of the column being sampled; row group i returns on rows_in[N-1-i]
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (sample && (x_q == XW'(j))) begin
          if ((~sync2_q[N-1-i]) == cells_q[i*N+j]) begin
            dbc_d[i*N+j] = '0;
          end else if (dbc_q[i*N+j] == CW'(DEBOUNCE_SCANS - 1)) begin
            cells_d[i*N+j] = ~cells_q[i*N+j];
            dbc_d[i*N+j]   = '0;
          end else begin
            dbc_d[i*N+j] = dbc_q[i*N+j] + CW'(1);
          end
        end
      end
    end
  end

  assign cols_out   = cols_q;
  assign x          = x_q;
  assign cells      = cells_q;
  assign frame_done = frame_q;

`ifdef KEY_SCANNER_EDGE_EN
  logic [N*N-1:0] pressed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed_q <= '0;
    end else begin
      pressed_q <= cells_d & ~cells_q;
    end
  end

  assign pressed = pressed_q;
`else
  assign pressed = '0;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Randomized bench for key_matrix_scanner: a time-indexed scan/debounce model is compared every cycle,
// with literal expectations for the directed scenarios.
module tb_key_matrix_scanner;

  localparam int N  = 3;
  localparam int S  = 4;
  localparam int D  = 2;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [N-1:0]  rows_in;
  logic [N-1:0]  cols_out;
  logic [2:0]    x;
  logic [NN-1:0] cells;
  logic          frame_done;
  logic [NN-1:0] pressed;
  logic [NN-1:0] keys;

  int checks = 0;
  int errors = 0;

  key_matrix_scanner #(.N(N), .SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rows_in(rows_in), .cols_out(cols_out),
    .x(x), .cells(cells), .frame_done(frame_done), .pressed(pressed)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its row low while its column is driven
  always_comb begin
    rows_in = '1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (keys[i*N+j] && cols_out[j]) rows_in[N-1-i] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: m_t counts cycles since the scan began; column = (m_t/S)%N, sample when m_t%S==S-1
  bit            m_scan;
  int            m_t;
  logic [NN-1:0] m_cells, m_pressed, m_old;
  int            m_cnt [NN];
  logic          m_frame;
  logic [N-1:0]  m_h1, m_h2, m_smp;
  int            m_col;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan = 0; m_t = 0; m_cells = '0; m_pressed = '0; m_frame = 1'b0;
      m_h1 = '1; m_h2 = '1;
      for (int k = 0; k < NN; k++) m_cnt[k] = 0;
    end else begin
      m_smp = m_h2; m_h2 = m_h1; m_h1 = rows_in;
      m_old = m_cells; m_frame = 1'b0;
      if (!m_scan) begin
        if (ena) begin m_scan = 1; m_t = 0; end
      end else if (!ena) begin
        m_scan = 0;
      end else begin
        if (m_t % S == S - 1) begin
          m_col = (m_t / S) % N;
          for (int i = 0; i < N; i++) begin
            int k;
            k = i * N + m_col;
            if (!m_smp[N-1-i] == m_cells[k]) m_cnt[k] = 0;
            else begin
              m_cnt[k]++;
              if (m_cnt[k] == D) begin m_cells[k] = ~m_cells[k]; m_cnt[k] = 0; end
            end
          end
          if (m_col == N - 1) m_frame = 1'b1;
        end
        m_t++;
      end
`ifdef KEY_SCANNER_EDGE_EN
      m_pressed = m_cells & ~m_old;
`else
      m_pressed = '0;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("cols_out",   32'(cols_out),   m_scan ? 32'(1 << ((m_t / S) % N)) : 32'd0);
      chk("x",          32'(x),          m_scan ? 32'((m_t / S) % N) : 32'd0);
      chk("cells",      32'(cells),      32'(m_cells));
      chk("frame_done", 32'(frame_done), 32'(m_frame));
      chk("pressed",    32'(pressed),    32'(m_pressed));
    end
  end

  initial begin
    int n;
    rst = 1'b1; ena = 1'b0; keys = '0;
    repeat (3) @(negedge clk);
    chk("rst_cells", 32'(cells), 32'd0);
    chk("rst_cols", 32'(cols_out), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_frame", 32'(frame_done), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);

    ena = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk("first_col", 32'(cols_out), 32'd1);
    chk("first_x", 32'(x), 32'd0);
    repeat (4) @(negedge clk);
    chk("second_col", 32'(cols_out), 32'd2);
    chk("second_x", 32'(x), 32'd1);

    n = 0;
    while (!frame_done && n < 40) begin @(negedge clk); n++; end
    chk("frame_seen", 32'(frame_done), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 40);
    chk("frame_period", 32'(n), 32'd12);

    // Stable press of row group 0, column 2
    keys = 9'h004;
    repeat (36) @(negedge clk);
    chk("stable_press", 32'(cells), 32'h004);
    keys = '0;
    repeat (36) @(negedge clk);
    chk("stable_release", 32'(cells), 32'h000);

    // Glitch: exactly one column-2 sample sees the press
    n = 0;
    while (!frame_done && n < 40) begin @(negedge clk); n++; end
    chk("glitch_align", 32'(frame_done), 32'd1);
    keys = 9'h004;
    repeat (12) @(negedge clk);
    keys = '0;
    repeat (36) @(negedge clk);
    chk("glitch_reject", 32'(cells), 32'h000);

    keys = 9'h101;
    repeat (36) @(negedge clk);
    chk("multi_key", 32'(cells), 32'h101);

    // Drop enable during column 1
    n = 0;
    while (x != 3'd1 && n < 40) begin @(negedge clk); n++; end
    chk("wait_x1", 32'(x), 32'd1);
    ena = 1'b0;
    @(negedge clk);
    chk("drop_cols", 32'(cols_out), 32'd0);
    chk("drop_x", 32'(x), 32'd0);
    chk("drop_cells", 32'(cells), 32'h101);
    repeat (5) @(negedge clk);
    chk("drop_hold", 32'(cells), 32'h101);
    ena = 1'b1;
    @(negedge clk);
    chk("resume_cols", 32'(cols_out), 32'd1);
    chk("resume_x", 32'(x), 32'd0);

    keys = '0;
    repeat (36) @(negedge clk);
    chk("multi_release", 32'(cells), 32'h000);

    // Async reset between edges
    keys = 9'h101;
    repeat (36) @(negedge clk);
    chk("pre_reset_cells", 32'(cells), 32'h101);
    #2 rst = 1'b1;
    #1;
    chk("async_cells", 32'(cells), 32'd0);
    chk("async_cols", 32'(cols_out), 32'd0);
    chk("async_frame", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0; keys = '0;

    // Random key patterns, hold times and enable drops
    for (int it = 0; it < 40; it++) begin
      keys = 9'($urandom & $urandom);
      if ($urandom_range(0, 5) == 0) begin
        ena = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        ena = 1'b1;
      end
      repeat ($urandom_range(3, 40)) @(negedge clk);
    end
    keys = '0;
    repeat (48) @(negedge clk);
    chk("final_cells", 32'(cells), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
